// File: rtl/rvv_vregfile_grouped.sv
// rvv_vregfile_grouped: RVV register file, N comb read ports, byte-enabled LMUL group write bursts.
// Define RVV_VREG_WR_BYPASS_EN to forward the beat being written to same-cycle reads.
module rvv_vregfile_grouped #(
   parameter int VLEN     = 512,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 3,
   parameter int AW       = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*VLEN-1:0]   rd_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [AW-1:0]            wr_base,
   input  logic [1:0]               wr_lmul,
   input  logic [VLEN-1:0]          wr_data,
   input  logic [VLEN/8-1:0]        wr_be,
   output logic [NUM_REGS-1:0]      busy,
   output logic                     wr_done,
   output logic                     err_misaligned
);
   typedef enum logic {IDLE, BURST} state_t;
   state_t state, state_n;
   logic [VLEN-1:0] regs [NUM_REGS];
   logic [VLEN-1:0] bmask, merged;
   logic [AW-1:0] ptr, ptr_n, wr_idx;
   logic [3:0] cnt, cnt_n, n;
   logic [NUM_REGS-1:0] busy_n;
   logic done_n, err_n, accept, misalign, do_write;
   always_comb begin
      n = 4'd1 << wr_lmul;
      misalign = ((int'(wr_base) & (int'(n) - 1)) != 0) || (int'(wr_base) >= NUM_REGS);
      accept = wr_valid && wr_ready;
      wr_idx = (state == BURST) ? ptr : wr_base;
      do_write = accept && (state == BURST || !misalign);
      for (int k = 0; k < VLEN/8; k++) bmask[8*k +: 8] = {8{wr_be[k]}};
      merged = (regs[wr_idx] & ~bmask) | (wr_data & bmask);
   end
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      cnt_n = cnt;
      busy_n = busy;
      done_n = 1'b0;
      err_n = 1'b0;
      if (accept && state == IDLE) begin
         if (misalign) err_n = 1'b1;
         else if (n == 4'd1) done_n = 1'b1;
         else begin
            state_n = BURST;
            ptr_n = wr_base + AW'(1);
            cnt_n = n - 4'd1;
            for (int r = 0; r < NUM_REGS; r++)
               busy_n[r] = (r > int'(wr_base)) && (r < int'(wr_base) + int'(n));
         end
      end else if (accept) begin
         busy_n[ptr] = 1'b0;
         ptr_n = ptr + AW'(1);
         cnt_n = cnt - 4'd1;
         if (cnt == 4'd1) begin
            state_n = IDLE;
            done_n = 1'b1;
            busy_n = '0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr <= '0;
         cnt <= '0;
         busy <= '0;
         wr_done <= 1'b0;
         err_misaligned <= 1'b0;
         wr_ready <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         cnt <= cnt_n;
         busy <= busy_n;
         wr_done <= done_n;
         err_misaligned <= err_n;
         wr_ready <= 1'b1;
         if (do_write) regs[wr_idx] <= merged;
      end
   end
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] a;
      assign a = rd_addr[i*AW +: AW];
`ifdef RVV_VREG_WR_BYPASS_EN
      assign rd_data[i*VLEN +: VLEN] = (int'(a) >= NUM_REGS) ? '0 :
                                       (do_write && a == wr_idx) ? merged : regs[a];
`else
      assign rd_data[i*VLEN +: VLEN] = (int'(a) >= NUM_REGS) ? '0 : regs[a];
`endif
   end
endmodule
